// File: rtl/cs_rr_arbiter_16.sv
// ============================================================================
// Module   : cs_rr_arbiter_16
// Brief    : 16-way round-robin chip-select arbiter, active-low one-hot
//            grants with bounded hold time and a one-cycle turnaround gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_rr_arbiter_16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_n,
    input  logic [15:0] req,
    output logic [15:0] gnt_n,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);

    logic [1:0]  r_state;
    logic [15:0] r_gnt_n;
    logic [3:0]  r_gnt_idx;
    logic        r_gnt_valid;
    logic [3:0]  r_last;
    logic [7:0]  r_hold_cnt;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_gnt_n_nxt;
    logic [3:0]  w_gnt_idx_nxt;
    logic        w_gnt_valid_nxt;
    logic [3:0]  w_last_nxt;
    logic [7:0]  w_hold_cnt_nxt;

    logic        w_found;
    logic [3:0]  w_winner;
    logic        w_arb_ok;
    logic        w_release;

    // Search last+1 .. last+16 (mod 16) so the previous owner is visited last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        for (int i = 1; i <= 16; i++) begin
            if (!w_found && req[r_last + 4'(i)]) begin
                w_found  = 1'b1;
                w_winner = r_last + 4'(i);
            end
        end
    end

    assign w_arb_ok  = ~en_n & w_found;
    assign w_release = ~req[r_gnt_idx] | en_n | (r_hold_cnt == C_MAX_HOLD);

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_n_nxt     = r_gnt_n;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_last_nxt      = r_last;
        w_hold_cnt_nxt  = r_hold_cnt;
        case (r_state)
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt     = ST_GAP;
                    w_gnt_n_nxt     = 16'hFFFF;
                    w_gnt_valid_nxt = 1'b0;
                    w_last_nxt      = r_gnt_idx;
                end else begin
                    w_hold_cnt_nxt  = r_hold_cnt + 8'd1;
                end
            end
            // IDLE and GAP both arbitrate; the gap itself is the state's single cycle.
            default: begin
                if (w_arb_ok) begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_n_nxt     = ~(16'h0001 << w_winner);
                    w_gnt_idx_nxt   = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = 8'd1;
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_n_nxt     = 16'hFFFF;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt_n     <= 16'hFFFF;
            r_gnt_idx   <= 4'd0;
            r_gnt_valid <= 1'b0;
            r_last      <= 4'hF;
            r_hold_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_n     <= w_gnt_n_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_last      <= w_last_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    assign gnt_n     = r_gnt_n;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

`default_nettype wire

// File: tb/tb_cs_rr_arbiter_16.sv
// ============================================================================
// Module   : tb_cs_rr_arbiter_16
// Brief    : Directed scoreboard bench for cs_rr_arbiter_16 (MAX_HOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cs_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_n;
    logic [15:0] req;
    logic [15:0] gnt_n;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          n_cycle      = 0;

    // Each entry: {valid, idx} expected after one clock edge.
    logic [4:0]  exp_q[$];

    cs_rr_arbiter_16 #(.MAX_HOLD(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en_n      (en_n),
        .req       (req),
        .gnt_n     (gnt_n),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    // Drive inputs for the next edge and record the outputs expected after it.
    task automatic step(input logic s_rst, input logic s_en_n, input logic [15:0] s_req,
                        input logic e_valid, input logic [3:0] e_idx);
        rst  = s_rst;
        en_n = s_en_n;
        req  = s_req;
        exp_q.push_back({e_valid, e_idx});
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        logic [4:0]  e;
        logic [15:0] e_n;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            e_n = 16'hFFFF;
            if (e[4]) e_n[e[3:0]] = 1'b0;
            n_compared++;
            if (gnt_n !== e_n || gnt_valid !== e[4] || gnt_idx !== e[3:0]) begin
                n_mismatched++;
                $display("FAIL cycle%0d grant: got gnt_n=%h valid=%b idx=%0d, expected gnt_n=%h valid=%b idx=%0d",
                         n_cycle, gnt_n, gnt_valid, gnt_idx, e_n, e[4], e[3:0]);
            end
            n_cycle++;
        end
    end

    initial begin
        // Reset, then idle with no requests
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 4'd0);

        // Single requester 5: 4 cycles granted, 1 cycle gap, repeating
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0020, 1'b1, 4'd5);
            step(1'b0, 1'b0, 16'h0020, 1'b0, 4'd5);
        end

        // Round robin across all 16 with wrap back to 0
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        for (int k = 0; k <= 16; k++) begin
            for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'hFFFF, 1'b1, 4'(k));
            step(1'b0, 1'b0, 16'hFFFF, 1'b0, 4'(k));
        end

        // Early release of 0, bit 0 re-raised in the gap still loses to 15
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        step(1'b0, 1'b0, 16'h8001, 1'b1, 4'd0);
        step(1'b0, 1'b0, 16'h8001, 1'b1, 4'd0);
        step(1'b0, 1'b0, 16'h8000, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h8001, 1'b1, 4'd15);
        step(1'b0, 1'b0, 16'h8001, 1'b0, 4'd15);
        step(1'b0, 1'b0, 16'h8001, 1'b1, 4'd0);

        // Enable gating on requester 3
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        step(1'b0, 1'b0, 16'h0008, 1'b1, 4'd3);
        step(1'b0, 1'b0, 16'h0008, 1'b1, 4'd3);
        step(1'b0, 1'b1, 16'h0008, 1'b0, 4'd3);
        step(1'b0, 1'b1, 16'h0008, 1'b0, 4'd3);
        step(1'b0, 1'b1, 16'h0008, 1'b0, 4'd3);
        step(1'b0, 1'b0, 16'h0008, 1'b1, 4'd3);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 4'd3);

        // Reset mid-grant on 7; priority restarts at 0 so 7 wins again
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        step(1'b0, 1'b0, 16'h0080, 1'b1, 4'd7);
        step(1'b0, 1'b0, 16'h0080, 1'b1, 4'd7);
        step(1'b1, 1'b0, 16'hFF80, 1'b0, 4'd0);
        step(1'b0, 1'b0, 16'hFF80, 1'b1, 4'd7);
        step(1'b0, 1'b0, 16'hFF80, 1'b1, 4'd7);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cs_rr_arbiter_16.md
# cs_rr_arbiter_16

Round-robin arbiter that shares one 16-slot chip-select space among 16 requesters. It drives active-low, one-hot select lines with the same encoding as the 4-to-16 decoder outputs: all ones when idle or disabled, exactly one zero when a grant is active. It also exports the granted index so a downstream 4-to-16 decoder or datapath mux can be steered from `gnt_idx`. A bounded hold time and a mandatory one-cycle turnaround gap between grants make it suitable for sequencing shared chip-select buses.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles a single grant stays asserted. Legal range is 1..255.
- `clk`, input, 1: single clock; everything samples on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en_n`, input, 1: active-low enable. When 1, no new grant is issued and any active grant is released.
- `req`, input, 16: active-high request, one bit per requester.
- `gnt_n`, output, 16: registered active-low one-hot grant. Value is 16'hFFFF when no grant is active.
- `gnt_idx`, output, 4: registered index of the current or most recent grant.
- `gnt_valid`, output, 1: registered, high exactly when `gnt_n` != 16'hFFFF.

## Operation
- State machine has three states: IDLE, GRANT, GAP.
- Internal state:
  - `last[3:0]`: last released index.
  - `hold_cnt[7:0]`: grant-cycle counter.
- Arbitration (evaluated at an edge in IDLE or GAP when `en_n`=0 and `req`!=0):
  - Winner is the first set bit of `req`, searching `last+1`, `last+2`, … with mod-16 wrap back to `last`.
  - The requester at `last` is considered only after all others.
  - If `req`=0 or `en_n`=1, no grant is issued and the FSM goes or stays in IDLE.
- On a grant edge:
  - `gnt_n[w]`←0 with all other bits 1; `gnt_idx`←w; `gnt_valid`←1.
  - `hold_cnt`←1; next state is GRANT.
- In GRANT, at each edge, release if any of these holds: `req[gnt_idx]`=0, `en_n`=1, or `hold_cnt`==MAX_HOLD.
  - Release: `gnt_n`←16'hFFFF, `gnt_valid`←0, `last`←`gnt_idx`, next state GAP. `gnt_idx` holds its value.
  - Otherwise: `hold_cnt`←`hold_cnt`+1 and the grant is unchanged.
- GAP lasts exactly one cycle with all selects deasserted. The edge that ends GAP performs arbitration exactly as IDLE does.
- Requests for other indices arriving during GRANT are ignored until the next arbitration. There is no preemption except by MAX_HOLD or `en_n`.
- Invariant: `gnt_n` never contains more than one zero, and `gnt_valid` == ~&`gnt_n` in every cycle.

## Timing
- Reset (`rst`=1 sampled at an edge) overrides everything, including mid-grant:
  - `gnt_n`=16'hFFFF, `gnt_valid`=0, `gnt_idx`=0.
  - `last`=15, so requester 0 has highest priority first; `hold_cnt`=0; state IDLE.
- Grant latency:
  - `req` sampled high at edge k in IDLE or GAP gives `gnt_n` low in the cycle after edge k.
- Grant duration:
  - With the request held, the grant is visible for exactly MAX_HOLD cycles.
  - If `req[gnt_idx]` falls before edge k, the grant deasserts after edge k (one-cycle release latency).
- Turnaround:
  - Minimum dead time between consecutive grants is exactly 1 cycle (GAP).
  - Back-to-back grants to the same requester are allowed when it is the only requester.
- `en_n` rising during GRANT releases the grant at the next edge, then the FSM passes through GAP into IDLE.
- `en_n`=1 while a request is sampled gives no grant. The request is granted at the first edge where `en_n`=0.
- Wrap-around: after releasing 15, the search order is 0, 1, …, 15.

## Test plan
- **Reset, no requests:** assert `rst` for 2 cycles, `req`=0 → `gnt_n`=16'hFFFF, `gnt_valid`=0, `gnt_idx`=0 for 10 cycles.
- **Single requester, MAX_HOLD=4:** hold `req`=16'h0020 → `gnt_n`=16'hFFDF for 4 cycles, 1 cycle of 16'hFFFF, repeating; `gnt_idx`=5 throughout.
- **Round robin with wrap:** `req`=16'hFFFF held, MAX_HOLD=4 → grant indices 0, 1, 2, …, 15, 0, each 4 cycles long, separated by 1 idle cycle.
- **Early release and mid-grant requests:** `req`=16'h8001, then drop bit 0 after 2 grant cycles → index 0 released after 2 cycles, GAP, then index 15 granted. Bit 0 re-raised during the GAP gets index 15 next, not 0 (last released was 0).
- **Enable gating:** grant active on index 3, raise `en_n` → release at the next edge. No grant while `en_n`=1; lowering `en_n` grants index 3 one cycle later if `req[3]`=1.
- **Reset mid-grant:** index 7 granted, pulse `rst` for 1 cycle → `gnt_n`=16'hFFFF after the edge. With `req`=16'hFF80, the next grant is index 7, since `last`=15 resets priority to 0 and 7 is the first set bit.
